// File: rtl/axis_packer_master.sv
// ---------------------------------------------------------------------------
// axis_packer_master
//
// AXI4-Stream master output stage. Narrow encoder units (IN_BYTES wide) are
// packed little-endian into wide beats (OUT_BYTES wide). Each completed beat
// is pushed into a small first-word-fall-through FIFO that drives the AXIS
// master port. A beat completes when all R = OUT_BYTES/IN_BYTES lanes are
// filled or when the unit is marked as the end of the packet. A short final
// beat carries a contiguous low tkeep mask, and its unfilled lanes are zero.
//
// Ports
//   m_axis_aclk    clock
//   m_axis_areset  synchronous reset, active-high
//   i_data         input unit (IN_BYTES*8)
//   i_valid        input unit present
//   i_data_end     current unit is the last of its packet
//   o_wait         input not accepted this cycle (FIFO full)
//   m_axis_tvalid  beat valid
//   m_axis_tdata   beat data (OUT_BYTES*8)
//   m_axis_tkeep   byte-lane valid mask
//   m_axis_tstrb   identical to tkeep
//   m_axis_tlast   last beat of packet
//   m_axis_tready  slave ready
//   o_pkt_count    completed packets, wraps
// ---------------------------------------------------------------------------
module axis_packer_master #(
  parameter int IN_BYTES      = 1,
  parameter int OUT_BYTES     = 4,
  parameter int FIFO_DEPTH    = 16,
  parameter int PKT_CNT_WIDTH = 16
) (
  input  logic                     m_axis_aclk,
  input  logic                     m_axis_areset,
  input  logic [IN_BYTES*8-1:0]    i_data,
  input  logic                     i_valid,
  input  logic                     i_data_end,
  output logic                     o_wait,
  output logic                     m_axis_tvalid,
  output logic [OUT_BYTES*8-1:0]   m_axis_tdata,
  output logic [OUT_BYTES-1:0]     m_axis_tkeep,
  output logic [OUT_BYTES-1:0]     m_axis_tstrb,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic [PKT_CNT_WIDTH-1:0] o_pkt_count
);

  localparam int R  = OUT_BYTES / IN_BYTES;
  localparam int LW = (R > 1) ? $clog2(R) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = OUT_BYTES * 8;

  logic [LW-1:0]        lane;
  logic [DW-1:0]        acc;
  logic [DW-1:0]        unit_ext;
  logic [DW-1:0]        merged;
  logic [OUT_BYTES-1:0] keep_new;
  logic                 accept;
  logic                 beat_done;
  logic                 push;
  logic                 pop;

  logic [DW-1:0]        mem_data [FIFO_DEPTH];
  logic [OUT_BYTES-1:0] mem_keep [FIFO_DEPTH];
  logic                 mem_last [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;

  // Back-pressure comes only from registered occupancy, so a pop in the
  // same cycle as a full FIFO does not let a new unit in until next cycle.
  assign o_wait    = (count == (AW+1)'(FIFO_DEPTH));
  assign accept    = i_valid && !o_wait;
  assign beat_done = accept && ((lane == LW'(R - 1)) || i_data_end);
  assign push      = beat_done;
  assign pop       = m_axis_tvalid && m_axis_tready;

  // The accumulator only ever holds lanes below the current index (it is
  // cleared when a beat completes), so OR-merging the shifted unit is safe
  // and leaves unfilled upper lanes at zero.
  always_comb begin
    unit_ext = '0;
    unit_ext[IN_BYTES*8-1:0] = i_data;
    merged   = acc | (unit_ext << (int'(lane) * IN_BYTES * 8));
    keep_new = '0;
    for (int b = 0; b < OUT_BYTES; b++) begin
      keep_new[b] = ((b / IN_BYTES) <= int'(lane));
    end
  end

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      acc  <= '0;
      lane <= '0;
    end else if (accept) begin
      if (beat_done) begin
        acc  <= '0;
        lane <= '0;
      end else begin
        acc  <= merged;
        lane <= lane + LW'(1);
      end
    end
  end

  // Storage needs no reset: the head is masked at the outputs while empty.
  always_ff @(posedge m_axis_aclk) begin
    if (push) begin
      mem_data[wr_ptr] <= merged;
      mem_keep[wr_ptr] <= keep_new;
      mem_last[wr_ptr] <= i_data_end;
    end
  end

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_pkt_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
      if (pop && m_axis_tlast) o_pkt_count <= o_pkt_count + PKT_CNT_WIDTH'(1);
    end
  end

  assign m_axis_tvalid = (count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? mem_data[rd_ptr] : '0;
  assign m_axis_tkeep  = m_axis_tvalid ? mem_keep[rd_ptr] : '0;
  assign m_axis_tstrb  = m_axis_tkeep;
  assign m_axis_tlast  = m_axis_tvalid && mem_last[rd_ptr];

endmodule

// File: tb/tb_axis_packer_master.sv
// ---------------------------------------------------------------------------
// tb_axis_packer_master
//
// Two instances share one stimulus driver and one reference model:
// dut_a packs 1-byte units, dut_b packs 2-byte units, both into 4-byte beats
// with a 4-entry FIFO. 'sel' chooses which instance is driven and observed.
// The reference model is a queue of expected beats plus the partial beat
// being assembled, updated once per clock from the packing rules.
// ---------------------------------------------------------------------------
module tb_axis_packer_master;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        drv_valid;
  logic [15:0] drv_unit;
  logic        drv_end;
  logic        rdy;

  logic        a_wait, a_tvalid, a_tlast;
  logic [31:0] a_tdata;
  logic [3:0]  a_tkeep, a_tstrb;
  logic [15:0] a_pkt;
  logic        b_wait, b_tvalid, b_tlast;
  logic [31:0] b_tdata;
  logic [3:0]  b_tkeep, b_tstrb;
  logic [15:0] b_pkt;

  logic        obs_wait, obs_tvalid, obs_tlast;
  logic [31:0] obs_tdata;
  logic [3:0]  obs_tkeep, obs_tstrb;
  logic [15:0] obs_pkt;

  int          checks   = 0;
  int          failures = 0;

  beat_t       expq[$];
  logic [31:0] part_data;
  int          part_n;
  int          exp_pkt;
  int          in_bytes;
  logic        acc_dummy;

  always #5 clk = ~clk;

  axis_packer_master #(
    .IN_BYTES(1), .OUT_BYTES(4), .FIFO_DEPTH(4), .PKT_CNT_WIDTH(16)
  ) dut_a (
    .m_axis_aclk  (clk),
    .m_axis_areset(rst),
    .i_data       (drv_unit[7:0]),
    .i_valid      (drv_valid && !sel),
    .i_data_end   (drv_end),
    .o_wait       (a_wait),
    .m_axis_tvalid(a_tvalid),
    .m_axis_tdata (a_tdata),
    .m_axis_tkeep (a_tkeep),
    .m_axis_tstrb (a_tstrb),
    .m_axis_tlast (a_tlast),
    .m_axis_tready(rdy),
    .o_pkt_count  (a_pkt)
  );

  axis_packer_master #(
    .IN_BYTES(2), .OUT_BYTES(4), .FIFO_DEPTH(4), .PKT_CNT_WIDTH(16)
  ) dut_b (
    .m_axis_aclk  (clk),
    .m_axis_areset(rst),
    .i_data       (drv_unit),
    .i_valid      (drv_valid && sel),
    .i_data_end   (drv_end),
    .o_wait       (b_wait),
    .m_axis_tvalid(b_tvalid),
    .m_axis_tdata (b_tdata),
    .m_axis_tkeep (b_tkeep),
    .m_axis_tstrb (b_tstrb),
    .m_axis_tlast (b_tlast),
    .m_axis_tready(rdy),
    .o_pkt_count  (b_pkt)
  );

  assign obs_wait   = sel ? b_wait   : a_wait;
  assign obs_tvalid = sel ? b_tvalid : a_tvalid;
  assign obs_tdata  = sel ? b_tdata  : a_tdata;
  assign obs_tkeep  = sel ? b_tkeep  : a_tkeep;
  assign obs_tstrb  = sel ? b_tstrb  : a_tstrb;
  assign obs_tlast  = sel ? b_tlast  : a_tlast;
  assign obs_pkt    = sel ? b_pkt    : a_pkt;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h (t=%0t sel=%0d)", tag, obs, exp, $time, sel);
    end
  endtask

  task automatic clearModel();
    expq.delete();
    part_data = '0;
    part_n    = 0;
    exp_pkt   = 0;
  endtask

  task automatic checkAll();
    checkOutput("o_wait", 32'(obs_wait), 32'(expq.size() == 4));
    checkOutput("tvalid", 32'(obs_tvalid), 32'(expq.size() != 0));
    if (expq.size() != 0) begin
      checkOutput("tdata", obs_tdata, expq[0].d);
      checkOutput("tkeep", 32'(obs_tkeep), 32'(expq[0].k));
      checkOutput("tstrb", 32'(obs_tstrb), 32'(expq[0].k));
      checkOutput("tlast", 32'(obs_tlast), 32'(expq[0].l));
    end
    checkOutput("pkt_count", 32'(obs_pkt), 32'(exp_pkt & 16'hFFFF));
  endtask

  // Called at a falling edge: check outputs, drive one cycle of inputs,
  // advance the model across the rising edge, return at the next fall.
  task automatic applyStimulus(input logic v, input logic [15:0] u, input logic e,
                               input logic r, output logic acc);
    int          units_per_beat;
    logic        full;
    logic        pop;
    logic [31:0] ue;
    beat_t       nb;
    checkAll();
    units_per_beat = 4 / in_bytes;
    full = (expq.size() == 4);
    acc  = v && !full;
    pop  = (expq.size() != 0) && r;
    drv_valid = v;
    drv_unit  = u;
    drv_end   = e;
    rdy       = r;
    @(posedge clk);
    if (pop) begin
      if (expq[0].l) exp_pkt++;
      void'(expq.pop_front());
    end
    if (acc) begin
      ue = (in_bytes == 1) ? {24'h0, u[7:0]} : {16'h0, u};
      part_data = part_data | (ue << (part_n * in_bytes * 8));
      part_n++;
      if (part_n == units_per_beat || e) begin
        nb.d = part_data;
        nb.k = 4'((1 << (part_n * in_bytes)) - 1);
        nb.l = e;
        expq.push_back(nb);
        part_data = '0;
        part_n    = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic sendUnit(input logic [15:0] u, input logic e, input logic r);
    logic acc;
    int   n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 64) begin
      applyStimulus(1'b1, u, e, r, acc);
      n++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout observed=not_accepted expected=accepted unit=0x%0h", u);
    end
  endtask

  task automatic idle(input int n, input logic r);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, 1'b0, r, acc);
  endtask

  task automatic doReset();
    drv_valid = 1'b0;
    drv_end   = 1'b0;
    drv_unit  = 16'h0;
    rdy       = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tvalid", 32'(obs_tvalid), 32'h0);
    checkOutput("rst_tdata", obs_tdata, 32'h0);
    checkOutput("rst_tkeep", 32'(obs_tkeep), 32'h0);
    checkOutput("rst_tlast", 32'(obs_tlast), 32'h0);
    checkOutput("rst_o_wait", 32'(obs_wait), 32'h0);
    checkOutput("rst_pkt_count", 32'(obs_pkt), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clearModel();
  endtask

  task automatic randomPhase(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), acc_dummy);
    end
    idle(12, 1'b1);
  endtask

  initial begin
    sel       = 1'b0;
    in_bytes  = 1;
    rst       = 1'b1;
    drv_valid = 1'b0;
    drv_unit  = 16'h0;
    drv_end   = 1'b0;
    rdy       = 1'b0;
    clearModel();
    @(negedge clk);
    doReset();

    // 8 bytes, two full beats
    for (int i = 1; i <= 8; i++) sendUnit(16'(i), (i == 8), 1'b1);
    idle(4, 1'b1);
    checkOutput("t1_pkt_count", 32'(obs_pkt), 32'd1);

    // 5 bytes, short final beat
    for (int i = 1; i <= 5; i++) sendUnit(16'(i), (i == 5), 1'b1);
    idle(4, 1'b1);

    // Fill the FIFO with tready low, try a refused unit, then drain
    for (int i = 1; i <= 16; i++) sendUnit(16'(i), 1'b0, 1'b0);
    checkOutput("t3_full_wait", 32'(obs_wait), 32'd1);
    checkOutput("t3_head", obs_tdata, 32'h04030201);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h00AA, 1'b0, 1'b0, acc_dummy);
    idle(1, 1'b0);
    idle(2, 1'b1);
    for (int i = 17; i <= 20; i++) sendUnit(16'(i), (i == 20), 1'b1);
    idle(8, 1'b1);

    // Partial packet discarded by reset
    sendUnit(16'h11, 1'b0, 1'b1);
    sendUnit(16'h22, 1'b0, 1'b1);
    doReset();
    for (int i = 1; i <= 4; i++) sendUnit(16'(i), (i == 4), 1'b1);
    idle(4, 1'b1);

    randomPhase(400);

    // Two-byte units
    sel      = 1'b1;
    in_bytes = 2;
    doReset();
    sendUnit(16'hBBAA, 1'b0, 1'b1);
    sendUnit(16'hDDCC, 1'b1, 1'b1);
    sendUnit(16'h1234, 1'b1, 1'b1);
    idle(4, 1'b1);
    checkOutput("t6_pkt_count", 32'(obs_pkt), 32'd2);

    randomPhase(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
